// File: rtl/tdm_demux4_if.sv
// Bus bundle for tdm_demux4: word input side, frame output side and error status.
interface tdm_demux4_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] d;
  logic         d_valid;
  logic         sync;
  logic         in_ready;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic         frame_valid;
  logic         frame_ready;
  logic         frame_err;
  logic [7:0]   err_count;

  // Producer of words and consumer of frames.
  modport master (
    output d, d_valid, sync, frame_ready,
    input  in_ready, y0, y1, y2, y3, frame_valid, frame_err, err_count
  );

  // The demultiplexer itself.
  modport slave (
    input  d, d_valid, sync, frame_ready,
    output in_ready, y0, y1, y2, y3, frame_valid, frame_err, err_count
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: collects words into y0..y3, presents a complete
// frame with a valid/ready handshake and counts syncs that arrive mid-frame.
module tdm_demux4 #(
  parameter int unsigned W = 4
) (
  input  logic        clk,
  input  logic        reset,
  tdm_demux4_if.slave bus
);
  localparam int unsigned SLOTS   = 4;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t       state_q;
  logic [1:0]   slot_q;
  logic [W-1:0] y_q [SLOTS];
  logic         frame_err_q;
  logic [7:0]   err_count_q;

  logic         in_ready_c;
  logic         in_xfer_c;
  logic         frame_xfer_c;
  logic         mid_sync_c;
  logic [1:0]   wr_slot_c;
  logic [1:0]   slot_d;

  // Handshake qualification and slot selection for the word arriving this cycle.
  always_comb begin
    in_ready_c   = (state_q == FILL) || bus.frame_ready;
    in_xfer_c    = bus.d_valid && in_ready_c;
    frame_xfer_c = (state_q == FULL) && bus.frame_ready;
    // A sync, or a word overlapping the frame release, always restarts at slot 0.
    wr_slot_c    = (bus.sync || (state_q == FULL)) ? 2'd0 : slot_q;
    slot_d       = wr_slot_c + 2'd1;
    mid_sync_c   = in_xfer_c && bus.sync && (state_q == FILL) && (slot_q != 2'd0);
  end

  // Fill/full FSM with slot registers, error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      slot_q      <= 2'd0;
      frame_err_q <= 1'b0;
      err_count_q <= 8'd0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        y_q[i] <= '0;
      end
    end else begin
      frame_err_q <= mid_sync_c;
      if (mid_sync_c && (err_count_q != ERR_MAX)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (in_xfer_c) begin
        y_q[wr_slot_c] <= bus.d;
        slot_q         <= slot_d;
        state_q        <= (wr_slot_c == 2'd3) ? FULL : FILL;
      end else if (frame_xfer_c) begin
        state_q <= FILL;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.frame_valid = (state_q == FULL);
  assign bus.frame_err   = frame_err_q;
  assign bus.err_count   = err_count_q;
  assign bus.y0          = y_q[0];
  assign bus.y1          = y_q[1];
  assign bus.y2          = y_q[2];
  assign bus.y3          = y_q[3];
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed frames against a queue-style frame model,
// plus literal expectations pinned at key points of each scenario.
module tb_tdm_demux4;
  localparam int unsigned W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  tdm_demux4_if #(.W(W)) bus ();

  tdm_demux4 #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Model: a partial-frame list, a held frame and an error tally.
  logic [W-1:0] m_part [4];
  int           m_part_n  = 0;
  bit           m_full    = 1'b0;
  logic [W-1:0] m_frame [4];
  int           m_err_cnt = 0;
  bit           m_pulse   = 1'b0;

  always @(posedge clk) begin : model
    bit acc;
    if (reset) begin
      m_part_n  = 0;
      m_full    = 1'b0;
      m_err_cnt = 0;
      m_pulse   = 1'b0;
    end else begin
      acc     = bus.d_valid && (!m_full || bus.frame_ready);
      m_pulse = 1'b0;
      if (m_full && bus.frame_ready) m_full = 1'b0;
      if (acc) begin
        if (bus.sync) begin
          if (m_part_n != 0) begin
            m_pulse = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
          end
          m_part_n = 0;
        end
        m_part[m_part_n] = bus.d;
        m_part_n++;
        if (m_part_n == 4) begin
          m_frame  = m_part;
          m_full   = 1'b1;
          m_part_n = 0;
        end
      end
    end
  end

  // Literal expectations posted by the stimulus for the next falling edge.
  bit           pin_y_on  = 1'b0;
  logic [W-1:0] pin_y [4];
  bit           pin_ir_on = 1'b0;
  logic         pin_ir    = 1'b0;
  bit           pin_ec_on = 1'b0;
  int           pin_ec    = 0;
  bit           pin_pc_on = 1'b0;
  int           pin_pc    = 0;
  int           pin_pc_base = 0;

  int n_chk      = 0;
  int n_fail     = 0;
  int dut_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model and any pinned literals.
  always @(negedge clk) begin : compare
    if (bus.frame_err === 1'b1) dut_pulses++;
    chk("in_ready", 32'(bus.in_ready), 32'(!m_full || bus.frame_ready));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_full));
    chk("frame_err", 32'(bus.frame_err), 32'(m_pulse));
    chk("err_count", 32'(bus.err_count), 32'(m_err_cnt));
    if (m_full) begin
      chk("y0", 32'(bus.y0), 32'(m_frame[0]));
      chk("y1", 32'(bus.y1), 32'(m_frame[1]));
      chk("y2", 32'(bus.y2), 32'(m_frame[2]));
      chk("y3", 32'(bus.y3), 32'(m_frame[3]));
    end
    if (pin_y_on) begin
      chk("pin_frame_valid", 32'(bus.frame_valid), 32'd1);
      chk("pin_y0", 32'(bus.y0), 32'(pin_y[0]));
      chk("pin_y1", 32'(bus.y1), 32'(pin_y[1]));
      chk("pin_y2", 32'(bus.y2), 32'(pin_y[2]));
      chk("pin_y3", 32'(bus.y3), 32'(pin_y[3]));
    end
    if (pin_ir_on) chk("pin_in_ready", 32'(bus.in_ready), 32'(pin_ir));
    if (pin_ec_on) chk("pin_err_count", 32'(bus.err_count), 32'(pin_ec));
    if (pin_pc_on) chk("pin_err_pulses", 32'(dut_pulses - pin_pc_base), 32'(pin_pc));
  end

  task automatic drive(input logic dv, input logic sy, input logic [W-1:0] dd, input logic fr);
    bus.d_valid     = dv;
    bus.sync        = sy;
    bus.d           = dd;
    bus.frame_ready = fr;
    @(posedge clk);
    #1;
    pin_y_on  = 1'b0;
    pin_ir_on = 1'b0;
    pin_ec_on = 1'b0;
    pin_pc_on = 1'b0;
  endtask

  task automatic expect_y(input logic [W-1:0] a, b, c, e);
    pin_y_on = 1'b1;
    pin_y[0] = a;
    pin_y[1] = b;
    pin_y[2] = c;
    pin_y[3] = e;
  endtask

  task automatic expect_ir(input logic v);
    pin_ir_on = 1'b1;
    pin_ir    = v;
  endtask

  task automatic expect_ec(input int v);
    pin_ec_on = 1'b1;
    pin_ec    = v;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.d           = '0;
    bus.d_valid     = 1'b0;
    bus.sync        = 1'b0;
    bus.frame_ready = 1'b0;
    reset           = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    expect_ec(0);
    expect_ir(1'b1);
    drive(1'b0, 1'b0, 4'd0, 1'b0);

    // Basic frame, then held under backpressure until released.
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 4'(i), 1'b0);
    expect_y(4'd1, 4'd2, 4'd3, 4'd4);
    expect_ir(1'b0);
    drive(1'b1, 1'b0, 4'd7, 1'b0);
    expect_y(4'd1, 4'd2, 4'd3, 4'd4);
    expect_ir(1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b1);

    // Back-to-back stream with the consumer always ready.
    for (int i = 1; i <= 8; i++) begin
      expect_ir(1'b1);
      if (i == 5) expect_y(4'd1, 4'd2, 4'd3, 4'd4);
      drive(1'b1, 1'b0, 4'(i), 1'b1);
    end
    expect_y(4'd5, 4'd6, 4'd7, 4'd8);
    drive(1'b0, 1'b0, 4'd0, 1'b1);

    // Mid-frame sync restarts the frame at the synced word.
    drive(1'b1, 1'b0, 4'd1, 1'b0);
    drive(1'b1, 1'b0, 4'd2, 1'b0);
    drive(1'b1, 1'b1, 4'd9, 1'b0);
    expect_ec(1);
    drive(1'b1, 1'b0, 4'd10, 1'b0);
    drive(1'b1, 1'b0, 4'd11, 1'b0);
    drive(1'b1, 1'b0, 4'd12, 1'b0);
    expect_y(4'd9, 4'd10, 4'd11, 4'd12);
    drive(1'b0, 1'b0, 4'd0, 1'b1);

    // Full frame held five cycles against a waiting word.
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 4'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_y(4'd1, 4'd2, 4'd3, 4'd4);
      expect_ir(1'b0);
      drive(1'b1, 1'b0, 4'd5, 1'b0);
    end
    expect_ir(1'b1);
    drive(1'b1, 1'b0, 4'd5, 1'b1);
    for (int i = 6; i <= 8; i++) drive(1'b1, 1'b0, 4'(i), 1'b0);
    expect_y(4'd5, 4'd6, 4'd7, 4'd8);
    drive(1'b0, 1'b0, 4'd0, 1'b1);

    // Reset after three words; the word offered during reset is dropped.
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 4'(i), 1'b0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'd4, 1'b0);
    reset = 1'b0;
    for (int i = 5; i <= 8; i++) drive(1'b1, 1'b0, 4'(i), 1'b0);
    expect_y(4'd5, 4'd6, 4'd7, 4'd8);
    expect_ec(0);
    drive(1'b0, 1'b0, 4'd0, 1'b1);

    // 260 mid-frame syncs saturate the counter but keep pulsing.
    drive(1'b1, 1'b1, 4'd0, 1'b0);
    pin_pc_base = dut_pulses;
    for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, 4'(i), 1'b0);
    expect_ec(255);
    pin_pc_on = 1'b1;
    pin_pc    = 260;
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
